// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-stage scoreboard for variable-latency execution units.
// Tracks one countdown per architectural register (cycles until its pending
// write retires) plus a writeback-slot vector so that at most one write
// retires per cycle. Produces the issue stall, operand bypass selects and the
// writeback announcement. All outputs are combinational from current state.
//
// Optional feature: define HAZARD_SCOREBOARD_STATS_EN to build a saturating
// 32-bit counter of stalled cycles on stall_cycles; otherwise it reads 0.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int REG_W = 5,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic             issue_use_rs,
  input  logic             issue_use_rt,
  input  logic             issue_writes,
  input  logic [REG_W-1:0] issue_dst,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             kill_last,
  output logic             stall,
  output logic             fwd_rs,
  output logic             fwd_rt,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_dst,
  output logic [REG_W:0]   pending_cnt,
  output logic [31:0]      stall_cycles
);

  localparam int NSLOT = 1 << LAT_W;
  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

  // cnt[r] == c > 0: register r retires at the end of the cycle in which c == 1.
  // slots[k] set: some write retires k cycles from now.
  logic [LAT_W-1:0] cnt [NREGS];
  logic [NSLOT-1:0] slots;
  logic             last_valid;
  logic [REG_W-1:0] last_dst;
  logic [LAT_W-1:0] last_lat;

  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] cnt_rs, cnt_rt, cnt_dst;
  logic             use_rs, use_rt, writer;
  logic             raw, waw, structural;
  logic             accept_wr, kill;
  logic [NSLOT-1:0] kill_mask, set_mask, slots_nxt;

  // A zero latency is issued as a single-cycle operation.
  assign lat_eff = (issue_lat == '0) ? ONE : issue_lat;

  // Hazard detection, bypass selection and next slot vector.
  // NOTE: every signal assigned here gets a value on every path; a missing
  // assignment on any branch would infer a latch.
  always_comb begin
    cnt_rs  = cnt[issue_rs];
    cnt_rt  = cnt[issue_rt];
    cnt_dst = cnt[issue_dst];

    use_rs = issue_use_rs && (issue_rs != '0);
    use_rt = issue_use_rt && (issue_rt != '0);
    writer = issue_writes && (issue_dst != '0);

    // A value retiring this cycle (cnt == 1) is on the bypass bus; anything
    // further out is not yet available.
    raw    = (use_rs && (cnt_rs > ONE)) || (use_rt && (cnt_rt > ONE));
    fwd_rs = use_rs && (cnt_rs == ONE);
    fwd_rt = use_rt && (cnt_rt == ONE);

    // Older write to the same register must not retire after this one, and
    // the retire cycle of this write must be free.
    waw        = writer && (cnt_dst > lat_eff);
    structural = writer && slots[lat_eff];

    // Stall is evaluated on pre-kill state, which can only over-stall.
    stall     = issue_valid && (raw || waw || structural);
    accept_wr = issue_valid && !stall && writer;
    kill      = kill_last && last_valid;

    // The killed write sits at bit last_lat-1 of the current vector; clear it
    // before shifting so a same-cycle new reservation is never disturbed.
    kill_mask = kill ? (NSLOT'(1) << (last_lat - ONE)) : '0;
    set_mask  = accept_wr ? (NSLOT'(1) << (lat_eff - ONE)) : '0;
    slots_nxt = ((slots & ~kill_mask) >> 1) | set_mask;
  end

  // Countdown, slot and last-reservation state.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the counter array is small and must start empty, so unlike a
      // data RAM it is reset explicitly.
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      slots      <= '0;
      last_valid <= 1'b0;
      last_dst   <= '0;
      last_lat   <= '0;
    end else begin
      // Register 0 is never reserved; its counter stays at its reset value.
      for (int r = 1; r < NREGS; r++) begin
        if (accept_wr && (issue_dst == REG_W'(r))) begin
          cnt[r] <= lat_eff;
        end else if (kill && (last_dst == REG_W'(r))) begin
          cnt[r] <= '0;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - ONE;
        end
      end
      slots      <= slots_nxt;
      last_valid <= accept_wr;
      if (accept_wr) begin
        last_dst <= issue_dst;
        last_lat <= lat_eff;
      end
    end
  end

  // Writeback announcement and pending population count. The slot rule keeps
  // the retiring register unique, so OR-merging indices is exact.
  always_comb begin
    wb_valid    = 1'b0;
    wb_dst      = '0;
    pending_cnt = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (cnt[r] == ONE) begin
        wb_valid = 1'b1;
        wb_dst   = wb_dst | REG_W'(r);
      end
      if (cnt[r] != '0) pending_cnt = pending_cnt + (REG_W+1)'(1);
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  // Saturating count of cycles in which issue was blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard
// against a reference model kept in absolute time: each register holds the
// cycle number at which its pending write retires, and the set of occupied
// retire cycles models the one-writeback-per-cycle rule.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int REG_W = 5;
  localparam int LAT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [REG_W-1:0] issue_rs, issue_rt, issue_dst;
  logic             issue_use_rs, issue_use_rt, issue_writes;
  logic [LAT_W-1:0] issue_lat;
  logic             kill_last;
  logic             stall, fwd_rs, fwd_rt, wb_valid;
  logic [REG_W-1:0] wb_dst;
  logic [REG_W:0]   pending_cnt;
  logic [31:0]      stall_cycles;

  hazard_scoreboard #(.NREGS(NREGS), .REG_W(REG_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_writes(issue_writes), .issue_dst(issue_dst), .issue_lat(issue_lat),
    .kill_last(kill_last),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int t = 1;              // current cycle number
  int wbt [NREGS];        // retire cycle of the pending write, 0 when none
  bit sched [int];        // retire cycles already taken
  bit lv;                 // a write was accepted in the previous cycle
  int l_dst, l_time;      // its register and retire cycle
  int stall_cnt;          // stalled cycles seen so far

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mcnt(input int r);
    if (r == 0 || wbt[r] < t) return 0;
    return wbt[r] - t + 1;
  endfunction

  function automatic void model_reset();
    foreach (wbt[r]) wbt[r] = 0;
    sched.delete();
    lv = 1'b0;
    stall_cnt = 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_fwd_rs"}, 32'(fwd_rs), 0);
    check({tag, "_fwd_rt"}, 32'(fwd_rt), 0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 0);
    check({tag, "_wb_dst"}, 32'(wb_dst), 0);
    check({tag, "_pending"}, 32'(pending_cnt), 0);
    check({tag, "_stall_cycles"}, stall_cycles, 0);
  endtask

  // One issue cycle: drive, compare against the model, advance the model.
  task automatic step(input bit v, input int rs, input int rt, input bit urs,
                      input bit urt, input bit wen, input int dst, input int lat,
                      input bit kill);
    int l, exp_dst, pend;
    bit raw, wr, waw, st, exp_stall, exp_wb;
    @(negedge clk);
    issue_valid  = v;
    issue_rs     = REG_W'(rs);
    issue_rt     = REG_W'(rt);
    issue_use_rs = urs;
    issue_use_rt = urt;
    issue_writes = wen;
    issue_dst    = REG_W'(dst);
    issue_lat    = LAT_W'(lat);
    kill_last    = kill;
    #1;
    l         = (lat == 0) ? 1 : lat;
    raw       = (urs && rs != 0 && mcnt(rs) > 1) || (urt && rt != 0 && mcnt(rt) > 1);
    wr        = wen && dst != 0;
    waw       = wr && mcnt(dst) > l;
    st        = wr && sched.exists(t + l);
    exp_stall = v && (raw || waw || st);
    exp_wb    = 1'b0;
    exp_dst   = 0;
    pend      = 0;
    for (int r = 1; r < NREGS; r++) begin
      if (wbt[r] == t) begin
        exp_wb  = 1'b1;
        exp_dst = r;
      end
      if (mcnt(r) > 0) pend++;
    end
    check("stall", 32'(stall), 32'(exp_stall));
    if (!exp_stall) begin
      check("fwd_rs", 32'(fwd_rs), 32'(urs && rs != 0 && mcnt(rs) == 1));
      check("fwd_rt", 32'(fwd_rt), 32'(urt && rt != 0 && mcnt(rt) == 1));
    end
    check("wb_valid", 32'(wb_valid), 32'(exp_wb));
    check("wb_dst", 32'(wb_dst), 32'(exp_dst));
    check("pending_cnt", 32'(pending_cnt), 32'(pend));
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, 32'(stall_cnt));
`else
    check("stall_cycles", stall_cycles, 0);
`endif
    if (exp_stall) stall_cnt++;
    if (kill && lv) begin
      sched.delete(l_time);
      wbt[l_dst] = 0;
    end
    if (v && !exp_stall && wr) begin
      wbt[dst]  = t + l;
      sched[t + l] = 1'b1;
      lv     = 1'b1;
      l_dst  = dst;
      l_time = t + l;
    end else begin
      lv = 1'b0;
    end
    @(posedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_op(input int dst, input int lat);
    step(1, 0, 0, 0, 0, 1, dst, lat, 0);
  endtask

  task automatic rd_op(input int rs, input int rt);
    step(1, rs, rt, rs != 0, rt != 0, 0, 0, 0, 0);
  endtask

  function automatic int pick_reg();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, NREGS - 1));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    reset = 1'b1;
    issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_use_rs = 1'b0;
    issue_use_rt = 1'b0; issue_writes = 1'b0; issue_dst = '0; issue_lat = '0;
    kill_last = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // RAW: r5 written with latency 3, read every following cycle.
    wr_op(5, 3);
    repeat (4) rd_op(5, 0);
    idle(2);

    // Single-cycle producer bypassed to the rt operand.
    wr_op(7, 1);
    rd_op(0, 7);
    idle(2);

    // Structural: r4 lat 4 one cycle after r3 lat 5 collides; retried next cycle.
    wr_op(3, 5);
    wr_op(4, 4);
    wr_op(4, 4);
    idle(8);

    // WAW: r9 lat 6 then r9 lat 2 retried until the older write is close enough.
    wr_op(9, 6);
    repeat (6) wr_op(9, 2);
    idle(8);

    // Kill: r2 lat 4 flushed; the kill-cycle reader sees pre-kill state.
    wr_op(2, 4);
    step(1, 2, 0, 1, 0, 0, 0, 0, 1);
    rd_op(2, 0);
    // Kill with nothing accepted last cycle is ignored.
    wr_op(6, 3);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // Latency 0 behaves as 1; register 0 never reserves or hazards.
    wr_op(8, 0);
    rd_op(8, 8);
    wr_op(0, 5);
    rd_op(0, 0);
    idle(4);

    // Randomized traffic concentrated on a few registers to provoke hazards.
    repeat (600) begin
      step($urandom_range(0, 3) != 0, pick_reg(), pick_reg(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, pick_reg(), int'($urandom_range(0, 7)),
           $urandom_range(0, 5) == 0);
    end
    idle(8);

    // Reset while three writes are in flight.
    wr_op(10, 7);
    wr_op(11, 5);
    wr_op(12, 3);
    @(negedge clk);
    issue_valid = 1'b1; issue_rs = REG_W'(10); issue_use_rs = 1'b1;
    issue_rt = REG_W'(11); issue_use_rt = 1'b1; issue_writes = 1'b0;
    kill_last = 1'b0;
    #1;
    check("inflight_stall", 32'(stall), 1);
    check("inflight_pending", 32'(pending_cnt), 3);
    #1;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    issue_valid = 1'b0; issue_use_rs = 1'b0; issue_use_rt = 1'b0;
    reset = 1'b0;
    wr_op(10, 7);
    repeat (8) rd_op(10, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
